// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access stage and its return stack.
package mem_access_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int STK_DEPTH = 8;
  localparam int STK_PTR_W = 3;
  localparam int MEM_AW    = 12;

  // Memory address comes either from the dedicated 12-bit operand or the ALU result.
  function automatic logic [MEM_AW-1:0] sel_addr(input logic              mem_src,
                                                 input logic [MEM_AW-1:0] non_alu,
                                                 input logic [31:0]       alu);
    return mem_src ? non_alu : alu[MEM_AW-1:0];
  endfunction

endpackage

// File: rtl/mem_access_unit_ret_stack.sv
// Circular 8-entry return-address stack: push/pop with registered output, overflow
// overwrites the oldest entry, underflow returns zero; both flag err for one cycle.
module ret_stack
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              err
);

  localparam logic [STK_PTR_W:0] FULL_CNT = (STK_PTR_W+1)'(STK_DEPTH);

  logic [DATA_W-1:0]    stk_mem [STK_DEPTH];
  logic [STK_PTR_W-1:0] sp;
  logic [STK_PTR_W:0]   cnt;
  logic [STK_PTR_W-1:0] top;
  logic                 empty;
  logic                 full;

  assign top   = sp - 1'b1;
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push && pop) begin
        if (!empty) stk_mem[top] <= din;
      end else if (push) begin
        stk_mem[sp] <= din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp       <= '0;
      cnt      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      err      <= 1'b0;
    end else begin
      dout_vld <= pop;
      err      <= 1'b0;
      if (push && pop) begin
        // Swap the top in place; depth is unchanged.
        if (empty) begin
          dout <= '0;
          err  <= 1'b1;
        end else begin
          dout <= stk_mem[top];
        end
      end else if (push) begin
        sp <= sp + 1'b1;
        if (full) err <= 1'b1;
        else      cnt <= cnt + 1'b1;
      end else if (pop) begin
        if (empty) begin
          dout <= '0;
          err  <= 1'b1;
        end else begin
          dout <= stk_mem[top];
          sp   <= top;
          cnt  <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: two-state memory handshake FSM with stall, MEM/WB registers and an
// optional return-address stack enabled by defining RET_STACK_EN.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_in,
  input  logic              MemWrite_in,
  input  logic              MemRead_in,
  input  logic              MemToReg_in,
  input  logic              MemSrc_in,
  input  logic              call_in,
  input  logic              ret_in,
  input  logic [4:0]        DestReg_in,
  input  logic [31:0]       ALU_addr_in,
  input  logic [11:0]       NON_ALU_addr_in,
  input  logic [31:0]       MemWrite_data_in,
  output logic              mem_re,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rdy,
  output logic              stall,
  output logic              RegWrite_out,
  output logic              MemToReg_out,
  output logic [4:0]        DestReg_out,
  output logic [31:0]       ALU_result_out,
  output logic [31:0]       rd_data_out,
  output logic [31:0]       ret_addr_out,
  output logic              ret_valid_out,
  output logic              stk_err
);

  state_t      state;
  logic        mem_op;
  logic        pend_rw_p1;
  logic        pend_rd_p1;
  logic        pend_m2r_p1;
  logic [4:0]  pend_dst_p1;
  logic [31:0] pend_res_p1;

  assign mem_op = MemRead_in | MemWrite_in;
  assign stall  = ~rst & (((state == IDLE) & mem_op) | ((state == BUSY) & ~mem_rdy));

  // Writeback fields of the in-flight access, captured on IDLE->BUSY.
  always_ff @(posedge clk) begin
    if (state == IDLE && mem_op) begin
      pend_m2r_p1 <= MemToReg_in;
      pend_dst_p1 <= DestReg_in;
      pend_res_p1 <= ALU_addr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      mem_re         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      pend_rw_p1     <= 1'b0;
      pend_rd_p1     <= 1'b0;
      RegWrite_out   <= 1'b0;
      MemToReg_out   <= 1'b0;
      DestReg_out    <= '0;
      ALU_result_out <= '0;
      rd_data_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state        <= BUSY;
            mem_re       <= MemRead_in;
            mem_we       <= ~MemRead_in & MemWrite_in;
            mem_addr     <= sel_addr(MemSrc_in, NON_ALU_addr_in, ALU_addr_in);
            mem_wdata    <= MemWrite_data_in;
            pend_rw_p1   <= RegWrite_in;
            pend_rd_p1   <= MemRead_in;
            RegWrite_out <= 1'b0;
          end else begin
            RegWrite_out   <= RegWrite_in;
            MemToReg_out   <= MemToReg_in;
            DestReg_out    <= DestReg_in;
            ALU_result_out <= ALU_addr_in;
          end
        end
        BUSY: begin
          if (mem_rdy) begin
            state          <= IDLE;
            mem_re         <= 1'b0;
            mem_we         <= 1'b0;
            RegWrite_out   <= pend_rw_p1;
            MemToReg_out   <= pend_m2r_p1;
            DestReg_out    <= pend_dst_p1;
            ALU_result_out <= pend_res_p1;
            if (pend_rd_p1) rd_data_out <= mem_rdata;
          end else begin
            RegWrite_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RET_STACK_EN
  logic stk_push;
  logic stk_pop;

  assign stk_push = call_in & ~stall;
  assign stk_pop  = ret_in & ~stall;

  ret_stack #(
    .DATA_W(32)
  ) u_ret_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (stk_push),
    .pop      (stk_pop),
    .din      (MemWrite_data_in),
    .dout     (ret_addr_out),
    .dout_vld (ret_valid_out),
    .err      (stk_err)
  );
`else
  logic unused_stk;

  assign unused_stk    = call_in | ret_in;
  assign ret_addr_out  = '0;
  assign ret_valid_out = 1'b0;
  assign stk_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of non-memory ops plus hand-written
// read/write/stack/reset sequences. Stack expectations collapse to 0 without RET_STACK_EN.
module tb_mem_access_unit;

`ifdef RET_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, MemSrc_in, call_in, ret_in;
  logic [4:0]  DestReg_in;
  logic [31:0] ALU_addr_in;
  logic [11:0] NON_ALU_addr_in;
  logic [31:0] MemWrite_data_in;
  logic        mem_re, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rdy;
  logic        stall;
  logic        RegWrite_out, MemToReg_out;
  logic [4:0]  DestReg_out;
  logic [31:0] ALU_result_out, rd_data_out, ret_addr_out;
  logic        ret_valid_out, stk_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk              (clk),
    .rst              (rst),
    .RegWrite_in      (RegWrite_in),
    .MemWrite_in      (MemWrite_in),
    .MemRead_in       (MemRead_in),
    .MemToReg_in      (MemToReg_in),
    .MemSrc_in        (MemSrc_in),
    .call_in          (call_in),
    .ret_in           (ret_in),
    .DestReg_in       (DestReg_in),
    .ALU_addr_in      (ALU_addr_in),
    .NON_ALU_addr_in  (NON_ALU_addr_in),
    .MemWrite_data_in (MemWrite_data_in),
    .mem_re           (mem_re),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_rdy          (mem_rdy),
    .stall            (stall),
    .RegWrite_out     (RegWrite_out),
    .MemToReg_out     (MemToReg_out),
    .DestReg_out      (DestReg_out),
    .ALU_result_out   (ALU_result_out),
    .rd_data_out      (rd_data_out),
    .ret_addr_out     (ret_addr_out),
    .ret_valid_out    (ret_valid_out),
    .stk_err          (stk_err)
  );

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic        exp_rw;
    logic        exp_m2r;
    logic [4:0]  exp_dst;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RegWrite_in = 0; MemWrite_in = 0; MemRead_in = 0; MemToReg_in = 0; MemSrc_in = 0;
    call_in = 0; ret_in = 0; DestReg_in = '0; ALU_addr_in = '0; NON_ALU_addr_in = '0;
    MemWrite_data_in = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int re_cnt, st_cnt;
    vecs[0] = '{1'b1, 1'b0, 5'd5,  32'h0000_1234, 1'b1, 1'b0, 5'd5,  32'h0000_1234};
    vecs[1] = '{1'b0, 1'b1, 5'd31, 32'hFFFF_F000, 1'b0, 1'b1, 5'd31, 32'hFFFF_F000};
    vecs[2] = '{1'b1, 1'b1, 5'd0,  32'h8000_0001, 1'b1, 1'b1, 5'd0,  32'h8000_0001};
    vecs[3] = '{1'b1, 1'b0, 5'd17, 32'h0000_0000, 1'b1, 1'b0, 5'd17, 32'h0000_0000};

    clear_inputs();
    rst = 1; mem_rdy = 0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_re", 32'(mem_re), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_regwrite", 32'(RegWrite_out), 0);
    chk("rst_result", ALU_result_out, 0);
    chk("rst_ret_valid", 32'(ret_valid_out), 0);
    rst = 0;

    // Non-memory ops: one-cycle latency, no stall
    for (int i = 0; i < 4; i++) begin
      RegWrite_in = vecs[i].rw; MemToReg_in = vecs[i].m2r;
      DestReg_in = vecs[i].dst; ALU_addr_in = vecs[i].alu;
      #1 chk("vec_stall", 32'(stall), 0);
      tick();
      chk("vec_regwrite", 32'(RegWrite_out), 32'(vecs[i].exp_rw));
      chk("vec_memtoreg", 32'(MemToReg_out), 32'(vecs[i].exp_m2r));
      chk("vec_dest", 32'(DestReg_out), 32'(vecs[i].exp_dst));
      chk("vec_result", ALU_result_out, vecs[i].exp_res);
    end
    clear_inputs();
    tick();

    // Read with three BUSY cycles
    RegWrite_in = 1; MemToReg_in = 1; DestReg_in = 5'd7; MemRead_in = 1; ALU_addr_in = 32'h0000_0ABC;
    re_cnt = 0; st_cnt = 0;
    #1 st_cnt += int'(stall);
    for (int i = 0; i < 3; i++) begin
      tick();
      re_cnt += int'(mem_re);
      chk("rd_addr", 32'(mem_addr), 32'h0ABC);
      chk("rd_we_low", 32'(mem_we), 0);
      chk("rd_bubble", 32'(RegWrite_out), 0);
      if (i == 2) begin mem_rdy = 1; mem_rdata = 32'hDEAD_BEEF; end
      #1 st_cnt += int'(stall);
    end
    tick();
    clear_inputs(); mem_rdy = 0; mem_rdata = '0;
    chk("rd_re_cycles", 32'(re_cnt), 3);
    chk("rd_stall_cycles", 32'(st_cnt), 3);
    chk("rd_re_done", 32'(mem_re), 0);
    chk("rd_data", rd_data_out, 32'hDEAD_BEEF);
    chk("rd_regwrite", 32'(RegWrite_out), 1);
    chk("rd_dest", 32'(DestReg_out), 7);
    tick();
    chk("rd_wb_pulse", 32'(RegWrite_out), 0);

    // Write completing in the first BUSY cycle, no writeback
    MemWrite_in = 1; MemSrc_in = 1; NON_ALU_addr_in = 12'h07F; ALU_addr_in = 32'h0000_0999;
    MemWrite_data_in = 32'h55AA_55AA;
    #1 chk("wr_stall_idle", 32'(stall), 1);
    tick();
    chk("wr_we", 32'(mem_we), 1);
    chk("wr_re_low", 32'(mem_re), 0);
    chk("wr_addr", 32'(mem_addr), 32'h07F);
    chk("wr_wdata", mem_wdata, 32'h55AA_55AA);
    mem_rdy = 1;
    #1 chk("wr_stall_busy", 32'(stall), 0);
    tick();
    clear_inputs(); mem_rdy = 0;
    chk("wr_we_done", 32'(mem_we), 0);
    chk("wr_no_wb", 32'(RegWrite_out), 0);
    chk("wr_rd_hold", rd_data_out, 32'hDEAD_BEEF);

    // Nine calls then nine rets
    for (int k = 1; k <= 9; k++) begin
      call_in = 1; MemWrite_data_in = 32'(k);
      tick();
      chk("call_err", 32'(stk_err), 32'(STK && k == 9));
    end
    call_in = 0;
    for (int k = 1; k <= 9; k++) begin
      ret_in = 1;
      tick();
      chk("ret_valid", 32'(ret_valid_out), 32'(STK));
      chk("ret_addr", ret_addr_out, STK ? ((k == 9) ? 32'd0 : 32'(10 - k)) : 32'd0);
      chk("ret_err", 32'(stk_err), 32'(STK && k == 9));
    end
    ret_in = 0;
    tick();
    chk("ret_valid_pulse", 32'(ret_valid_out), 0);

    // Simultaneous call and ret swaps the top
    call_in = 1; MemWrite_data_in = 32'h40;
    tick();
    ret_in = 1; MemWrite_data_in = 32'h80;
    tick();
    chk("swap_addr", ret_addr_out, STK ? 32'h40 : 32'h0);
    chk("swap_valid", 32'(ret_valid_out), 32'(STK));
    chk("swap_err", 32'(stk_err), 0);
    call_in = 0;
    tick();
    chk("swap_ret_addr", ret_addr_out, STK ? 32'h80 : 32'h0);
    ret_in = 0;

    // Reset in the second BUSY cycle of a read abandons it and empties the stack
    call_in = 1; MemWrite_data_in = 32'h11;
    tick();
    call_in = 0; RegWrite_in = 1; MemRead_in = 1; ALU_addr_in = 32'h123;
    tick();
    tick();
    chk("rb_re_busy", 32'(mem_re), 1);
    rst = 1; clear_inputs();
    tick();
    rst = 0; mem_rdy = 1; mem_rdata = 32'hCAFE_F00D;
    chk("rb_re", 32'(mem_re), 0);
    chk("rb_stall", 32'(stall), 0);
    chk("rb_regwrite", 32'(RegWrite_out), 0);
    tick();
    chk("rb_no_wb", 32'(RegWrite_out), 0);
    chk("rb_rd_data", rd_data_out, 0);
    mem_rdy = 0;
    ret_in = 1;
    tick();
    ret_in = 0;
    chk("rb_stk_empty_addr", ret_addr_out, 0);
    chk("rb_stk_empty_err", 32'(stk_err), 32'(STK));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
